axi_sram_wr_bridge: RTL and testbench

- AXI3 slave-side write bridge: accepts AW/W bursts and drives a single-cycle synchronous SRAM write port (ram_waddr/ram_wdata/ram_wen).
- Returns one B response per burst. Write-path counterpart of the read bridge; both share the same SRAM macro and top-level AXI port bundle.
- One outstanding write burst at a time.

---
 rtl/axi_sram_wr_bridge.sv | 178 +++++++++++++++++
 tb/tb_axi_sram_wr_bridge.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_sram_wr_bridge.sv
`default_nettype none
// ============================================================================
// Module   : axi_sram_wr_bridge
// Brief    : AXI3 slave write bridge onto a single-cycle synchronous SRAM
//            write port. One outstanding burst; one B response per burst.
//            Optional macro AXI_SRAM_WR_WRAP_BURST_EN enables WRAP bursts;
//            without it WRAP bursts drain with no writes and BRESP=SLVERR.
// Revision : 1.0 - initial release
// ============================================================================
module axi_sram_wr_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int LEN_WIDTH  = 4
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [ADDR_WIDTH-1:0]   m_awaddr,
  input  logic [1:0]              m_awburst,
  input  logic [ID_WIDTH-1:0]     m_awid,
  input  logic [LEN_WIDTH-1:0]    m_awlen,
  input  logic [2:0]              m_awsize,
  input  logic                    m_awvalid,
  output logic                    m_awready,
  input  logic [DATA_WIDTH-1:0]   m_wdata,
  input  logic [ID_WIDTH-1:0]     m_wid,
  input  logic [DATA_WIDTH/8-1:0] m_wstrb,
  input  logic                    m_wlast,
  input  logic                    m_wvalid,
  output logic                    m_wready,
  output logic [ID_WIDTH-1:0]     m_bid,
  output logic [1:0]              m_bresp,
  output logic                    m_bvalid,
  input  logic                    m_bready,
  output logic [ADDR_WIDTH-1:0]   ram_waddr,
  output logic [DATA_WIDTH-1:0]   ram_wdata,
  output logic [DATA_WIDTH/8-1:0] ram_wen
);

  localparam int c_strb_width = DATA_WIDTH / 8;
  localparam logic [2:0] c_max_size = 3'($clog2(c_strb_width));
  localparam logic [ADDR_WIDTH-1:0] c_addr_one = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [LEN_WIDTH-1:0]  c_len_one  = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

`ifdef AXI_SRAM_WR_WRAP_BURST_EN
  localparam logic c_wrap_en = 1'b1;
`else
  localparam logic c_wrap_en = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_next_state;
  logic [ID_WIDTH-1:0]     r_id;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [LEN_WIDTH-1:0]    r_len;
  logic [2:0]              r_size;
  logic [1:0]              r_burst;
  logic [LEN_WIDTH-1:0]    r_cnt;
  logic                    r_err;      // any error in this burst -> SLVERR
  logic                    r_cfg_err;  // illegal AW attributes -> suppress writes

  logic                    w_aw_hs;
  logic                    w_w_hs;
  logic                    w_last_beat;
  logic                    w_len_ok;
  logic                    w_aw_err;
  logic [ADDR_WIDTH-1:0]   w_bytes;
  logic [ADDR_WIDTH-1:0]   w_aligned;
  logic [ADDR_WIDTH-1:0]   w_incr;
  logic [ADDR_WIDTH-1:0]   w_win;
  logic [ADDR_WIDTH-1:0]   w_wmask;
  logic [ADDR_WIDTH-1:0]   w_wrap;
  logic [ADDR_WIDTH-1:0]   w_next_addr;

  assign w_aw_hs     = m_awvalid & m_awready;
  assign w_w_hs      = m_wvalid & m_wready;
  assign w_last_beat = (r_cnt == r_len);

  // AW attribute check: reserved burst, oversize beat, or an unsupported WRAP.
  assign w_len_ok = (m_awlen == LEN_WIDTH'(1)) | (m_awlen == LEN_WIDTH'(3)) |
                    (m_awlen == LEN_WIDTH'(7)) | (m_awlen == LEN_WIDTH'(15));
  assign w_aw_err = (m_awburst == 2'b11) | (m_awsize > c_max_size) |
                    ((m_awburst == 2'b10) & (~c_wrap_en | ~w_len_ok));

  // Next beat address: INCR aligns to the beat size, WRAP stays in its window.
  assign w_bytes   = c_addr_one << r_size;
  assign w_aligned = r_addr & ~(w_bytes - c_addr_one);
  assign w_incr    = w_aligned + w_bytes;
  assign w_win     = ({{(ADDR_WIDTH-LEN_WIDTH){1'b0}}, r_len} + c_addr_one) << r_size;
  assign w_wmask   = w_win - c_addr_one;
  assign w_wrap    = (w_aligned & ~w_wmask) | (w_incr & w_wmask);

  // Select the post-beat address by burst type; FIXED holds.
  always_comb begin
    w_next_addr = r_addr;
    case (r_burst)
      2'b01:   w_next_addr = w_incr;
      2'b10:   w_next_addr = w_wrap;
      default: w_next_addr = r_addr;
    endcase
  end

  // FSM state register.
  always_ff @(posedge aclk) begin
    if (areset) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // FSM next state and channel handshake outputs.
  always_comb begin
    w_next_state = r_state;
    m_awready    = 1'b0;
    m_wready     = 1'b0;
    m_bvalid     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        m_awready = ~areset;
        if (m_awvalid) w_next_state = ST_DATA;
      end
      ST_DATA: begin
        m_wready = 1'b1;
        // awlen, not wlast, decides where the burst ends.
        if (m_wvalid && w_last_beat) w_next_state = ST_RESP;
      end
      ST_RESP: begin
        m_bvalid = 1'b1;
        if (m_bready) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Burst context: latch AW, step address/count per beat, collect errors.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_id      <= '0;
      r_addr    <= '0;
      r_len     <= '0;
      r_size    <= '0;
      r_burst   <= '0;
      r_cnt     <= '0;
      r_err     <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      if (w_aw_hs) begin
        r_id      <= m_awid;
        r_addr    <= m_awaddr;
        r_len     <= m_awlen;
        r_size    <= m_awsize;
        r_burst   <= m_awburst;
        r_cnt     <= '0;
        r_err     <= w_aw_err;
        r_cfg_err <= w_aw_err;
      end
      if (w_w_hs) begin
        r_addr <= w_next_addr;
        if (!w_last_beat) r_cnt <= r_cnt + c_len_one;
        if ((m_wid != r_id) || (m_wlast != w_last_beat)) r_err <= 1'b1;
      end
    end
  end

  // Protocol errors (WID/WLAST) only affect the response; the data itself is
  // still written. Only illegal AW attributes block the SRAM write.
  assign ram_waddr = r_addr;
  assign ram_wdata = m_wdata;
  assign ram_wen   = (w_w_hs && !r_cfg_err) ? m_wstrb : '0;
  assign m_bid     = r_id;
  assign m_bresp   = r_err ? 2'b10 : 2'b00;

endmodule
`default_nettype wire

// File: tb/tb_axi_sram_wr_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_sram_wr_bridge
// Brief    : Self-checking bench for axi_sram_wr_bridge: a table of directed
//            bursts plus hand-written multi-cycle sequences.
//            Expected WRAP behaviour follows AXI_SRAM_WR_WRAP_BURST_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_sram_wr_bridge;

`ifdef AXI_SRAM_WR_WRAP_BURST_EN
  localparam logic c_wrap_on = 1'b1;
`else
  localparam logic c_wrap_on = 1'b0;
`endif
  localparam logic [1:0] c_wrap_resp = c_wrap_on ? 2'b00 : 2'b10;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic [31:0] m_awaddr = '0;
  logic [1:0]  m_awburst = '0;
  logic [3:0]  m_awid = '0;
  logic [3:0]  m_awlen = '0;
  logic [2:0]  m_awsize = '0;
  logic        m_awvalid = 1'b0;
  logic        m_awready;
  logic [31:0] m_wdata = '0;
  logic [3:0]  m_wid = '0;
  logic [3:0]  m_wstrb = '0;
  logic        m_wlast = 1'b0;
  logic        m_wvalid = 1'b0;
  logic        m_wready;
  logic [3:0]  m_bid;
  logic [1:0]  m_bresp;
  logic        m_bvalid;
  logic        m_bready = 1'b0;
  logic [31:0] ram_waddr;
  logic [31:0] ram_wdata;
  logic [3:0]  ram_wen;

  int total = 0;
  int bad   = 0;

  axi_sram_wr_bridge #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4), .LEN_WIDTH(4)
  ) dut (
    .aclk(aclk), .areset(areset),
    .m_awaddr(m_awaddr), .m_awburst(m_awburst), .m_awid(m_awid),
    .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awvalid(m_awvalid),
    .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wid(m_wid), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .ram_waddr(ram_waddr), .ram_wdata(ram_wdata), .ram_wen(ram_wen)
  );

  always #5 aclk = ~aclk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at 1ms, required to finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0]       burst;
    logic [31:0]      addr;
    logic [3:0]       len;
    logic [2:0]       size;
    logic [3:0]       id;
    logic [3:0][3:0]  strb;      // per beat, beat 0 in [0]
    logic [3:0][31:0] exp_addr;  // per beat, beat 0 in [0]
    logic             wen_on;    // 1: ram_wen must equal wstrb; 0: must be 0
    logic [1:0]       exp_resp;
  } vec_t;

  vec_t vt [9];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic timeout_fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s: no handshake within 50 cycles (got none, required one)", nm);
  endtask

  // Present an AW request and hold it until accepted. Entered at posedge+1.
  task automatic do_aw(input logic [1:0] bu, input logic [31:0] ad, input logic [3:0] ln,
                       input logic [2:0] sz, input logic [3:0] id);
    int n;
    m_awburst = bu; m_awaddr = ad; m_awlen = ln; m_awsize = sz; m_awid = id;
    m_awvalid = 1'b1;
    n = 0;
    @(negedge aclk);
    while (!m_awready && n < 50) begin n++; @(negedge aclk); end
    if (!m_awready) timeout_fail("aw_wait");
    @(posedge aclk); #1;
    m_awvalid = 1'b0;
  endtask

  // Present one W beat, check the SRAM port in the handshake cycle.
  task automatic do_beat(input logic [3:0] wid, input logic [3:0] strb, input logic [31:0] data,
                         input logic last, input logic chk, input logic [3:0] exp_wen,
                         input logic [31:0] exp_addr, input string nm);
    int n;
    m_wid = wid; m_wstrb = strb; m_wdata = data; m_wlast = last; m_wvalid = 1'b1;
    n = 0;
    @(negedge aclk);
    while (!m_wready && n < 50) begin n++; @(negedge aclk); end
    if (!m_wready) timeout_fail({nm, "_wready"});
    else if (chk) begin
      check({nm, "_wen"}, 64'(ram_wen), 64'(exp_wen));
      if (exp_wen != 4'h0) begin
        check({nm, "_addr"}, 64'(ram_waddr), 64'(exp_addr));
        check({nm, "_data"}, 64'(ram_wdata), 64'(data));
      end
    end
    @(posedge aclk); #1;
    m_wvalid = 1'b0; m_wlast = 1'b0;
  endtask

  // Hold bready low for 'hold' cycles, then take the B response.
  task automatic get_b(input logic [3:0] id, input logic [1:0] resp, input int hold, input string nm);
    int n;
    m_bready = 1'b0;
    for (int k = 0; k < hold; k++) begin
      @(negedge aclk);
      check({nm, "_hold_bvalid"}, 64'(m_bvalid), 64'd1);
      check({nm, "_hold_awready"}, 64'(m_awready), 64'd0);
      @(posedge aclk); #1;
    end
    m_bready = 1'b1;
    n = 0;
    @(negedge aclk);
    while (!m_bvalid && n < 50) begin n++; @(negedge aclk); end
    if (!m_bvalid) timeout_fail({nm, "_bvalid"});
    else begin
      check({nm, "_bid"}, 64'(m_bid), 64'(id));
      check({nm, "_bresp"}, 64'(m_bresp), 64'(resp));
    end
    @(posedge aclk); #1;
    m_bready = 1'b0;
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    v = vt[i];
    do_aw(v.burst, v.addr, v.len, v.size, v.id);
    for (int b = 0; b <= int'(v.len); b++) begin
      do_beat(v.id, v.strb[b], 32'hD000_0000 | 32'(i << 8) | 32'(b), (b == int'(v.len)), 1'b1,
              v.wen_on ? v.strb[b] : 4'h0, v.exp_addr[b], $sformatf("vec%0d_b%0d", i, b));
    end
    get_b(v.id, v.exp_resp, 0, $sformatf("vec%0d", i));
  endtask

  initial begin
    // burst, addr, len, size, id, strb{b3,b2,b1,b0}, addr{b3,b2,b1,b0}, wen_on, resp
    vt[0] = '{2'b01, 32'h100, 4'd3, 3'd2, 4'd5, {4'hF, 4'hF, 4'hF, 4'hF},
              {32'h10C, 32'h108, 32'h104, 32'h100}, 1'b1, 2'b00};
    vt[1] = '{2'b00, 32'h40, 4'd1, 3'd2, 4'd2, {4'h0, 4'h0, 4'hC, 4'h3},
              {32'h0, 32'h0, 32'h40, 32'h40}, 1'b1, 2'b00};
    vt[2] = '{2'b10, 32'h38, 4'd3, 3'd2, 4'd7, {4'hF, 4'hF, 4'hF, 4'hF},
              {32'h34, 32'h30, 32'h3C, 32'h38}, c_wrap_on, c_wrap_resp};
    vt[3] = '{2'b01, 32'h101, 4'd2, 3'd2, 4'd1, {4'h0, 4'hF, 4'hF, 4'hE},
              {32'h0, 32'h108, 32'h104, 32'h101}, 1'b1, 2'b00};
    vt[4] = '{2'b01, 32'h200, 4'd1, 3'd3, 4'd3, {4'h0, 4'h0, 4'hF, 4'hF},
              {32'h0, 32'h0, 32'h208, 32'h200}, 1'b0, 2'b10};
    vt[5] = '{2'b11, 32'h10, 4'd0, 3'd2, 4'd4, {4'h0, 4'h0, 4'h0, 4'hF},
              {32'h0, 32'h0, 32'h0, 32'h10}, 1'b0, 2'b10};
    vt[6] = '{2'b10, 32'h20, 4'd2, 3'd2, 4'd6, {4'h0, 4'hF, 4'hF, 4'hF},
              {32'h0, 32'h0, 32'h0, 32'h0}, 1'b0, 2'b10};
    vt[7] = '{2'b01, 32'h7, 4'd3, 3'd0, 4'd8, {4'h1, 4'h2, 4'h4, 4'h8},
              {32'hA, 32'h9, 32'h8, 32'h7}, 1'b1, 2'b00};
    vt[8] = '{2'b10, 32'h44, 4'd1, 3'd2, 4'd9, {4'h0, 4'h0, 4'h5, 4'hA},
              {32'h0, 32'h0, 32'h40, 32'h44}, c_wrap_on, c_wrap_resp};

    // Reset: hold, then check idle outputs.
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("rst_awready_in_reset", 64'(m_awready), 64'd0);
    @(posedge aclk); #1;
    areset = 1'b0;
    @(negedge aclk);
    check("rst_awready", 64'(m_awready), 64'd1);
    check("rst_wready", 64'(m_wready), 64'd0);
    check("rst_bvalid", 64'(m_bvalid), 64'd0);
    check("rst_bresp", 64'(m_bresp), 64'd0);
    check("rst_bid", 64'(m_bid), 64'd0);
    check("rst_wen", 64'(ram_wen), 64'd0);
    @(posedge aclk); #1;

    // Directed burst table.
    for (int i = 0; i < 9; i++) run_vec(i);

    // Early wlast on beat 1 of a 3-beat INCR: all 3 beats accepted, SLVERR.
    do_aw(2'b01, 32'h300, 4'd2, 3'd2, 4'd3);
    do_beat(4'd3, 4'hF, 32'h1111_0000, 1'b0, 1'b1, 4'hF, 32'h300, "wlast_b0");
    do_beat(4'd3, 4'hF, 32'h1111_0001, 1'b1, 1'b0, 4'h0, 32'h0, "wlast_b1");
    do_beat(4'd3, 4'hF, 32'h1111_0002, 1'b0, 1'b0, 4'h0, 32'h0, "wlast_b2");
    get_b(4'd3, 2'b10, 0, "wlast");

    // WID mismatch: data still written, SLVERR returned with the AW id.
    do_aw(2'b01, 32'h380, 4'd1, 3'd2, 4'd6);
    do_beat(4'd7, 4'hF, 32'h2222_0000, 1'b0, 1'b1, 4'hF, 32'h380, "wid_b0");
    do_beat(4'd7, 4'hF, 32'h2222_0001, 1'b1, 1'b0, 4'h0, 32'h0, "wid_b1");
    get_b(4'd6, 2'b10, 0, "wid");

    // W waiting in IDLE is stalled; simultaneous AW+W accepts only AW.
    m_wid = 4'd4; m_wstrb = 4'h6; m_wdata = 32'h3333_0000; m_wlast = 1'b1; m_wvalid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge aclk);
      check("idle_w_stall", 64'(m_wready), 64'd0);
      @(posedge aclk); #1;
    end
    m_awburst = 2'b01; m_awaddr = 32'h480; m_awlen = 4'd0; m_awsize = 3'd2; m_awid = 4'd4;
    m_awvalid = 1'b1;
    @(negedge aclk);
    check("sim_awready", 64'(m_awready), 64'd1);
    check("sim_wready", 64'(m_wready), 64'd0);
    check("sim_wen", 64'(ram_wen), 64'd0);
    @(posedge aclk); #1;
    m_awvalid = 1'b0;
    @(negedge aclk);
    check("sim_beat_wready", 64'(m_wready), 64'd1);
    check("sim_beat_wen", 64'(ram_wen), 64'h6);
    check("sim_beat_addr", 64'(ram_waddr), 64'h480);
    @(posedge aclk); #1;
    m_wvalid = 1'b0; m_wlast = 1'b0;
    get_b(4'd4, 2'b00, 0, "sim");

    // bready held low 5 cycles with a pending AW; AW accepted one cycle later.
    do_aw(2'b01, 32'h600, 4'd0, 3'd2, 4'd1);
    do_beat(4'd1, 4'hF, 32'h4444_0000, 1'b1, 1'b1, 4'hF, 32'h600, "pa_b0");
    m_awburst = 2'b01; m_awaddr = 32'h700; m_awlen = 4'd0; m_awsize = 3'd2; m_awid = 4'd2;
    m_awvalid = 1'b1;
    get_b(4'd1, 2'b00, 5, "pa");
    @(negedge aclk);
    check("pa_awready_after_b", 64'(m_awready), 64'd1);
    @(posedge aclk); #1;
    m_awvalid = 1'b0;
    @(negedge aclk);
    check("pa_aw_taken", 64'(m_wready), 64'd1);
    @(posedge aclk); #1;
    do_beat(4'd2, 4'hF, 32'h4444_0001, 1'b1, 1'b1, 4'hF, 32'h700, "pa2_b0");
    get_b(4'd2, 2'b00, 0, "pa2");

    // Reset during beat 2 of an 8-beat burst: burst abandoned, no response.
    do_aw(2'b01, 32'h500, 4'd7, 3'd2, 4'd9);
    do_beat(4'd9, 4'hF, 32'h5555_0000, 1'b0, 1'b1, 4'hF, 32'h500, "rb_b0");
    do_beat(4'd9, 4'hF, 32'h5555_0001, 1'b0, 1'b1, 4'hF, 32'h504, "rb_b1");
    m_wid = 4'd9; m_wstrb = 4'hF; m_wdata = 32'h5555_0002; m_wvalid = 1'b1;
    areset = 1'b1;
    @(negedge aclk);
    check("rb_awready_in_reset", 64'(m_awready), 64'd0);
    @(posedge aclk); #1;
    areset = 1'b0; m_wvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge aclk);
      check("rb_no_bvalid", 64'(m_bvalid), 64'd0);
      check("rb_awready", 64'(m_awready), 64'd1);
      check("rb_wready", 64'(m_wready), 64'd0);
      @(posedge aclk); #1;
    end
    run_vec(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
